regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-back end of the addressing-mode path: accepts register write requests (data + register address, as produced for MOV/MVI/LDA), buffers them in a shallow queue, and commits them to the 8-entry general register file under a write-back strobe. It also serves the two operand read ports (op1/op2), forwarding not-yet-committed queued writes, and exposes the accumulator (register 0) directly.

## Interface
- DATA_W, 16, register and data width
- ADDR_W, 16, width of register-address buses
- NREGS, 8, number of registers; register 0 is the accumulator
- QDEPTH, 2, write-queue depth (fixed 2; other values unsupported)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  1  write request present
- wr_ready  out  1  queue can accept; equals queue not full (registered count, not dependent on wr_valid/wb_en)
- wr_regaddr  in  ADDR_W  destination register
- wr_data  in  DATA_W  write data
- wb_en  in  1  write-back strobe; permits committing the queue head this cycle
- rd1_regaddr, rd2_regaddr  in  ADDR_W  operand read addresses
- rd1_data, rd2_data  out  DATA_W  combinational read data
- acc_data  out  DATA_W  committed value of register 0 (no forwarding)
- pending  out  2  queue occupancy 0..2
- addr_err  out  1  one-cycle pulse: rejected out-of-range write

## Operation
- Accept = wr_valid && wr_ready at a rising edge.
- Accepted with wr_regaddr < NREGS: enqueued at tail.
- Accepted with wr_regaddr >= NREGS: not enqueued, no register changes; addr_err = 1 for the following cycle only.
- wr_valid with wr_ready = 0: no effect; source must hold request.
- Commit: at edge where wb_en = 1 and pending > 0, head entry written to register array and popped. At most one commit per cycle.
- Queue FSM on pending: EMPTY(0), ONE(1), FULL(2). Enqueue only -> +1; commit only -> -1; both same edge -> unchanged, FIFO order preserved (ONE with both: old head committed, new entry becomes head). In FULL wr_ready = 0, so enqueue and commit never coincide in FULL.
- Reads: addr >= NREGS -> 0. Else youngest matching valid queue entry (tail over head), else register array. Both ports independent, same rule.
- wr_data is not bypassed to reads in the acceptance cycle.
- Same address queued twice: both commit in order; final value is the younger.
- Reset (any cycle, including mid-queue): all registers 0, queue emptied (pending writes discarded), addr_err 0, wr_ready 1.

## Timing
- Reset values: rd1_data/rd2_data 0, acc_data 0, pending 0, wr_ready 1, addr_err 0.
- Write accepted at edge N: visible on rd ports via forwarding from cycle N+1; earliest commit at edge N+1 if wb_en = 1 in cycle N+1; acc_data updates after commit edge.
- addr_err high exactly during the cycle after the rejecting edge; back-to-back rejects keep it high.
- wr_ready, pending, acc_data are pure register outputs; rd*_data combinational from rd*_regaddr and state.
- Throughput: one write/cycle sustained when wb_en held high.

## Structure
- Shared package cpu_pkg: DATA_W, ADDR_W, NREGS, REG_ACC = 0, wr_req_t struct {addr, data}.
- Sub-module wb_queue: 2-entry FIFO of wr_req_t with push/pop/count and both entries + valid bits exposed for forwarding lookup. Top holds register array, read/forward mux, range check, addr_err.

## Test plan
- Reset then read all 8 addresses -> all 0; pending 0, wr_ready 1, acc_data 0.
- Write R3 = 0x1234 with wb_en = 0 -> rd1(R3) = 0x1234 next cycle via forwarding, pending 1; assert wb_en -> commit, pending 0, rd1(R3) still 0x1234.
- Two writes R0 = 0x00AA then R0 = 0x00BB, wb_en = 0 -> pending 2, wr_ready 0, rd2(R0) = 0x00BB, acc_data 0; third write held; wb_en two cycles -> acc_data 0x00AA then 0x00BB.
- Write to address 0x0009 -> addr_err one-cycle pulse, pending unchanged, all registers unchanged, rd1(0x0009) = 0.
- pending 1 (R5 = 0x1111), same cycle wb_en = 1 and new write R5 = 0x2222 -> pending stays 1, R5 array = 0x1111, read R5 = 0x2222; next commit -> array 0x2222.
- Queue full (R1 = 0x0F0F, R2 = 0xF0F0), assert rst one cycle -> pending 0, rd(R1) = rd(R2) = 0, wr_ready 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and sizes for the register write-back path.
package cpu_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int NREGS   = 8;
  localparam int REG_ACC = 0;
  localparam int QDEPTH  = 2;
  localparam int IDX_W   = $clog2(NREGS);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_t;

endpackage

// File: rtl/wb_queue.sv
// Two-entry FIFO of register write requests; both slots are exposed for forwarding.
module wb_queue
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  wr_req_t    push_req,
  input  logic       pop,
  output logic [1:0] count,
  output wr_req_t    ent0,
  output wr_req_t    ent1,
  output logic       vld0,
  output logic       vld1
);

  q_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= Q_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      Q_EMPTY: if (push) state_nxt = Q_ONE;
      Q_ONE: begin
        if (push && !pop)      state_nxt = Q_FULL;
        else if (pop && !push) state_nxt = Q_EMPTY;
      end
      Q_FULL:  if (pop) state_nxt = Q_ONE;
      default: state_nxt = Q_EMPTY;
    endcase
  end

  // Slot 0 is always the head; slot 1 holds the younger entry when full.
  always_ff @(posedge clk) begin
    case (state)
      Q_EMPTY: if (push) ent0 <= push_req;
      Q_ONE: begin
        if (push && pop) ent0 <= push_req;
        else if (push)   ent1 <= push_req;
      end
      Q_FULL:  if (pop) ent0 <= ent1;
      default: ;
    endcase
  end

  assign count = state;
  assign vld0  = (state != Q_EMPTY);
  assign vld1  = (state == Q_FULL);

endmodule

// File: rtl/regfile_writeback.sv
// Register file with a two-deep write-back queue, forwarding reads and range-checked writes.
module regfile_writeback
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_regaddr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] rd1_regaddr,
  input  logic [ADDR_W-1:0] rd2_regaddr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic [DATA_W-1:0] acc_data,
  output logic [1:0]        pending,
  output logic              addr_err
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              accept, in_range, push, pop;
  wr_req_t           push_req, ent0, ent1;
  logic              vld0, vld1;
  logic [1:0]        count;

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] reg_val,
    input wr_req_t           e0,
    input logic              v0,
    input wr_req_t           e1,
    input logic              v1
  );
    if (addr >= ADDR_W'(NREGS)) return '0;
    if (v1 && e1.addr == addr)  return e1.data;
    if (v0 && e0.addr == addr)  return e0.data;
    return reg_val;
  endfunction

  assign wr_ready      = (count != 2'(QDEPTH));
  assign accept        = wr_valid && wr_ready;
  assign in_range      = (wr_regaddr < ADDR_W'(NREGS));
  assign push          = accept && in_range;
  assign pop           = wb_en && vld0;
  assign push_req.addr = wr_regaddr;
  assign push_req.data = wr_data;

  wb_queue u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .count    (count),
    .ent0     (ent0),
    .ent1     (ent1),
    .vld0     (vld0),
    .vld1     (vld1)
  );

  // Commit stage: queue head lands in the array on the write-back strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      addr_err <= 1'b0;
    end else begin
      if (pop) regs[ent0.addr[IDX_W-1:0]] <= ent0.data;
      addr_err <= accept && !in_range;
    end
  end

  assign rd1_data = read_port(rd1_regaddr, regs[rd1_regaddr[IDX_W-1:0]], ent0, vld0, ent1, vld1);
  assign rd2_data = read_port(rd2_regaddr, regs[rd2_regaddr[IDX_W-1:0]], ent0, vld0, ent1, vld1);
  assign acc_data = regs[REG_ACC];
  assign pending  = count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a queue-based reference model.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_regaddr;
  logic [15:0] wr_data;
  logic        wb_en;
  logic [15:0] rd1_regaddr, rd2_regaddr;
  logic [15:0] rd1_data, rd2_data, acc_data;
  logic [1:0]  pending;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mregs [8];
  logic        merr;

  regfile_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_regaddr  (wr_regaddr),
    .wr_data     (wr_data),
    .wb_en       (wb_en),
    .rd1_regaddr (rd1_regaddr),
    .rd2_regaddr (rd2_regaddr),
    .rd1_data    (rd1_data),
    .rd2_data    (rd2_data),
    .acc_data    (acc_data),
    .pending     (pending),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mread(input logic [15:0] addr);
    if (addr >= 16'd8) return 16'h0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == addr) return mq[i].d;
    return mregs[addr[2:0]];
  endfunction

  // Reference model: pop (commit) the oldest first, then append the accepted write.
  always @(posedge clk) begin
    bit   acc;
    ent_t e;
    if (rst) begin
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
      mq.delete();
      merr = 1'b0;
    end else begin
      acc = wr_valid && (mq.size() < 2);
      if (wb_en && mq.size() > 0) begin
        e = mq.pop_front();
        mregs[e.a[2:0]] = e.d;
      end
      if (acc && wr_regaddr < 16'd8) begin
        e.a = wr_regaddr;
        e.d = wr_data;
        mq.push_back(e);
      end
      merr = acc && (wr_regaddr >= 16'd8);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rd1", rd1_data, mread(rd1_regaddr));
      chk("m_rd2", rd2_data, mread(rd2_regaddr));
      chk("m_acc", acc_data, mregs[0]);
      chk("m_pending", pending, mq.size());
      chk("m_wr_ready", wr_ready, mq.size() < 2);
      chk("m_addr_err", addr_err, merr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    wr_valid   = 1'b1;
    wr_regaddr = a;
    wr_data    = d;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_regaddr = 16'h0; wr_data = 16'h0;
    wb_en = 1'b0; rd1_regaddr = 16'h0; rd2_regaddr = 16'h0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      rd1_regaddr = 16'(i);
      rd2_regaddr = 16'(7 - i);
      #1;
      chk("reset_rd1", rd1_data, 16'h0);
      chk("reset_rd2", rd2_data, 16'h0);
    end
    chk("reset_pending", pending, 2'd0);
    chk("reset_ready", wr_ready, 1'b1);
    chk("reset_acc", acc_data, 16'h0);
    chk("reset_err", addr_err, 1'b0);

    // Forwarding then commit of R3
    wr(16'd3, 16'h1234); rd1_regaddr = 16'd3;
    tick();
    wr_valid = 1'b0;
    #1;
    chk("fwd_r3", rd1_data, 16'h1234);
    chk("fwd_pending", pending, 2'd1);
    wb_en = 1'b1;
    tick();
    wb_en = 1'b0;
    #1;
    chk("commit_pending", pending, 2'd0);
    chk("commit_r3", rd1_data, 16'h1234);

    // Two writes to R0, queue full, third held
    rd2_regaddr = 16'd0;
    wr(16'd0, 16'h00AA);
    tick();
    wr(16'd0, 16'h00BB);
    tick();
    wr(16'd0, 16'h00CC);
    #1;
    chk("full_pending", pending, 2'd2);
    chk("full_ready", wr_ready, 1'b0);
    chk("full_rd2", rd2_data, 16'h00BB);
    chk("full_acc", acc_data, 16'h0);
    tick();
    chk("held_pending", pending, 2'd2);
    wb_en = 1'b1;
    tick();
    chk("acc_first", acc_data, 16'h00AA);
    chk("acc_first_pending", pending, 2'd1);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("acc_second", acc_data, 16'h00BB);
    chk("held_entry_fwd", rd2_data, 16'h00CC);
    tick();
    wb_en = 1'b0;
    chk("acc_third", acc_data, 16'h00CC);

    // Out-of-range writes
    rd1_regaddr = 16'h0009;
    wr(16'h0009, 16'h5555);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("err_pulse", addr_err, 1'b1);
    chk("err_pending", pending, 2'd0);
    chk("err_rd1", rd1_data, 16'h0);
    tick();
    chk("err_drop", addr_err, 1'b0);
    wr(16'hFFFF, 16'h1);
    tick();
    wr(16'h0008, 16'h2);
    tick();
    wr_valid = 1'b0;
    chk("err_b2b", addr_err, 1'b1);
    tick();
    chk("err_b2b_drop", addr_err, 1'b0);

    // Simultaneous enqueue and commit in ONE
    rd1_regaddr = 16'd5;
    wr(16'd5, 16'h1111);
    tick();
    wr(16'd5, 16'h2222); wb_en = 1'b1;
    tick();
    wr_valid = 1'b0; wb_en = 1'b0;
    #1;
    chk("both_pending", pending, 2'd1);
    chk("both_rd_r5", rd1_data, 16'h2222);
    wb_en = 1'b1;
    tick();
    wb_en = 1'b0;
    chk("both_commit_pending", pending, 2'd0);
    chk("both_commit_r5", rd1_data, 16'h2222);

    // Sustained one write per cycle
    wb_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr(16'((i * 3) % 8), 16'(16'hA000 + i));
      rd1_regaddr = 16'((i * 3) % 8);
      rd2_regaddr = 16'((i + 1) % 8);
      tick();
    end
    wr_valid = 1'b0;
    tick(); tick();
    wb_en = 1'b0;
    chk("stream_acc", acc_data, 16'hA000);

    // Reset with a full queue
    wr(16'd1, 16'h0F0F);
    tick();
    wr(16'd2, 16'hF0F0);
    tick();
    wr_valid = 1'b0;
    rd1_regaddr = 16'd1; rd2_regaddr = 16'd2;
    #1;
    chk("prerst_pending", pending, 2'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_pending", pending, 2'd0);
    chk("rst_rd1", rd1_data, 16'h0);
    chk("rst_rd2", rd2_data, 16'h0);
    chk("rst_ready", wr_ready, 1'b1);
    chk("rst_acc", acc_data, 16'h0);
    tick(); tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
